// File: rtl/glcm_engine_p.sv
// GLCM engine: pulls an IMG_DIM x IMG_DIM image over AXI4 INCR-16 reads, accumulates a
// LEVELS x LEVELS co-occurrence matrix for one (dir, dis) offset, and writes it back over AXI4.
module glcm_engine_p #(
  parameter int IMG_DIM   = 16,
  parameter int GRAY_BITS = 5,
  parameter int CNT_W     = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr_M,
  input  logic [ADDR_W-1:0] in_addr_G,
  input  logic [1:0]        in_dir,
  input  logic [3:0]        in_dis,
  input  logic              in_sym,
  output logic              busy,
  output logic              out_valid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready,
  output logic [3:0]        dbg_state
);
  localparam int LEVELS = 1 << GRAY_BITS;
  localparam int NCELL  = LEVELS * LEVELS;
  localparam int NPIX   = IMG_DIM * IMG_DIM;
  localparam int NR     = NPIX / 64;
  localparam int NW     = NCELL / 64;
  localparam int IW     = $clog2(IMG_DIM);
  localparam int CW     = IW + 1;
  localparam int RBW    = $clog2(NR) + 1;
  localparam int WBW    = $clog2(NW) + 1;
  localparam int PBW    = $clog2(NPIX / 4);
  localparam int CIW    = 2 * GRAY_BITS;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload are held steady until that edge.
  typedef enum logic [3:0] {
    S_IDLE, S_RD_AR, S_RD_R, S_ACCUM, S_WR_AW, S_WR_W, S_WR_B, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_m_q, addr_m_d, addr_g_q, addr_g_d;
  logic [1:0]          dir_q, dir_d;
  logic [3:0]          dis_q, dis_d;
  logic                sym_q, sym_d, ph_q, ph_d;
  logic [RBW-1:0]      rb_q, rb_d;
  logic [PBW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]       r_q, r_d, c_q, c_d;
  logic [WBW-1:0]      wb_q, wb_d;
  logic [3:0]          wbeat_q, wbeat_d;

  logic [GRAY_BITS-1:0] img_q [NPIX];
  logic [CNT_W-1:0]     cnt_q [NCELL];
  logic                 img_we, cnt_we, cnt_clr;

  logic                 job_ok, last_pair;
  logic [CW-1:0]        d_w, dr, nr, nc, c_min, c_max, r_max;
  logic [GRAY_BITS-1:0] pix_a, pix_b;
  logic [CIW-1:0]       cnt_idx, wbase;
  logic [CNT_W-1:0]     cnt_cur, cnt_inc;

  // Pairs with an in-range neighbour form a rectangle of reference pixels; scanning only
  // that rectangle skips out-of-range pairs without spending cycles on them.
  always_comb begin
    d_w    = CW'(dis_q);
    job_ok = (dis_q != 4'd0) && (int'(dis_q) < IMG_DIM);
    dr     = (dir_q == 2'b01) ? '0 : d_w;
    c_min  = (dir_q == 2'b00) ? d_w : '0;
    c_max  = (dir_q == 2'b01 || dir_q == 2'b11) ? CW'(IMG_DIM - 1) - d_w : CW'(IMG_DIM - 1);
    r_max  = (dir_q == 2'b01) ? CW'(IMG_DIM - 1) : CW'(IMG_DIM - 1) - d_w;
    nr     = {1'b0, r_q} + dr;
    case (dir_q)
      2'b01, 2'b11: nc = {1'b0, c_q} + d_w;
      2'b00:        nc = {1'b0, c_q} - d_w;
      default:      nc = {1'b0, c_q};
    endcase
    pix_a     = img_q[{r_q, c_q}];
    pix_b     = img_q[{nr[IW-1:0], nc[IW-1:0]}];
    cnt_idx   = ph_q ? {pix_b, pix_a} : {pix_a, pix_b};
    cnt_cur   = cnt_q[cnt_idx];
    cnt_inc   = (cnt_cur == '1) ? cnt_cur : cnt_cur + CNT_W'(1);
    last_pair = ({1'b0, c_q} == c_max) && ({1'b0, r_q} == r_max);
  end

  always_comb begin
    state_d  = state_q;
    addr_m_d = addr_m_q;
    addr_g_d = addr_g_q;
    dir_d    = dir_q;
    dis_d    = dis_q;
    sym_d    = sym_q;
    ph_d     = ph_q;
    rb_d     = rb_q;
    ptr_d    = ptr_q;
    r_d      = r_q;
    c_d      = c_q;
    wb_d     = wb_q;
    wbeat_d  = wbeat_q;
    img_we   = 1'b0;
    cnt_we   = 1'b0;
    cnt_clr  = 1'b0;
    arvalid  = 1'b0;
    rready   = 1'b0;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    wlast    = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_m_d = in_addr_M;
          addr_g_d = in_addr_G;
          dir_d    = in_dir;
          dis_d    = in_dis;
          sym_d    = in_sym;
          cnt_clr  = 1'b1;
          rb_d     = '0;
          ptr_d    = '0;
          wb_d     = '0;
          wbeat_d  = '0;
          ph_d     = 1'b0;
          state_d  = S_RD_AR;
        end
      end
      S_RD_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_RD_R;
      end
      S_RD_R: begin
        rready = 1'b1;
        if (rvalid) begin
          img_we = 1'b1;
          ptr_d  = ptr_q + PBW'(1);
          if (rlast) begin
            if (rb_q == RBW'(NR - 1)) begin
              r_d     = '0;
              c_d     = c_min[IW-1:0];
              ph_d    = 1'b0;
              state_d = S_ACCUM;
            end else begin
              rb_d    = rb_q + RBW'(1);
              state_d = S_RD_AR;
            end
          end
        end
      end
      S_ACCUM: begin
        if (!job_ok) begin
          state_d = S_WR_AW;
        end else begin
          // The count array is read and written in the same cycle, so consecutive
          // updates to one cell always see the latest value.
          cnt_we = 1'b1;
          if (sym_q && !ph_q) begin
            ph_d = 1'b1;
          end else begin
            ph_d = 1'b0;
            if (last_pair) begin
              state_d = S_WR_AW;
            end else if ({1'b0, c_q} == c_max) begin
              r_d = r_q + IW'(1);
              c_d = c_min[IW-1:0];
            end else begin
              c_d = c_q + IW'(1);
            end
          end
        end
      end
      S_WR_AW: begin
        awvalid = 1'b1;
        if (awready) state_d = S_WR_W;
      end
      S_WR_W: begin
        wvalid = 1'b1;
        wlast  = (wbeat_q == 4'hF);
        if (wready) begin
          wbeat_d = wbeat_q + 4'd1;
          if (wbeat_q == 4'hF) state_d = S_WR_B;
        end
      end
      S_WR_B: begin
        if (bvalid) begin
          if (wb_q == WBW'(NW - 1)) begin
            state_d = S_DONE;
          end else begin
            wb_d    = wb_q + WBW'(1);
            state_d = S_WR_AW;
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wbase = CIW'({wb_q, wbeat_q, 2'b00});
    wdata = '0;
    for (int j = 0; j < DATA_W / 8; j++) begin
      wdata[8*j +: 8] = cnt_q[wbase + CIW'(j)];
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign araddr    = addr_m_q + ADDR_W'({rb_q, 6'b0});
  assign awaddr    = addr_g_q + ADDR_W'({wb_q, 6'b0});
  assign arlen     = 4'hF;
  assign awlen     = 4'hF;
  assign bready    = 1'b1;
  assign dbg_state = state_q;

  logic unused_bits;
  assign unused_bits = ^{nr[CW-1], nc[CW-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_m_q <= '0;
      addr_g_q <= '0;
      dir_q    <= '0;
      dis_q    <= '0;
      sym_q    <= 1'b0;
      ph_q     <= 1'b0;
      rb_q     <= '0;
      ptr_q    <= '0;
      r_q      <= '0;
      c_q      <= '0;
      wb_q     <= '0;
      wbeat_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_m_q <= addr_m_d;
      addr_g_q <= addr_g_d;
      dir_q    <= dir_d;
      dis_q    <= dis_d;
      sym_q    <= sym_d;
      ph_q     <= ph_d;
      rb_q     <= rb_d;
      ptr_q    <= ptr_d;
      r_q      <= r_d;
      c_q      <= c_d;
      wb_q     <= wb_d;
      wbeat_q  <= wbeat_d;
    end
  end

  // Only the low GRAY_BITS of each byte lane are kept as the pixel value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPIX; i++) img_q[i] <= '0;
      for (int i = 0; i < NCELL; i++) cnt_q[i] <= '0;
    end else begin
      if (img_we) begin
        for (int j = 0; j < 4; j++) img_q[{ptr_q, 2'(j)}] <= rdata[8*j +: GRAY_BITS];
      end
      if (cnt_clr) begin
        for (int i = 0; i < NCELL; i++) cnt_q[i] <= '0;
      end else if (cnt_we) begin
        cnt_q[cnt_idx] <= cnt_inc;
      end
    end
  end
endmodule

// File: tb/tb_glcm_engine_p.sv
// Bench for glcm_engine_p: pseudo-DRAM read/write slaves, reference GLCM model feeding
// an expected-byte queue that is drained as the matrix is written back.
module tb_glcm_engine_p;
  localparam int IMG_DIM = 16;
  localparam int LEVELS  = 32;
  localparam int NCELL   = LEVELS * LEVELS;
  localparam int NPIX    = IMG_DIM * IMG_DIM;

  logic        clk, rst;
  logic        in_valid, in_sym;
  logic [31:0] in_addr_M, in_addr_G;
  logic [1:0]  in_dir;
  logic [3:0]  in_dis;
  logic        busy, out_valid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [3:0]  arlen, awlen, dbg_state;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  glcm_engine_p dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr_M(in_addr_M), .in_addr_G(in_addr_G),
    .in_dir(in_dir), .in_dis(in_dis), .in_sym(in_sym), .busy(busy), .out_valid(out_valid),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard
  logic [7:0]  exp_q[$];
  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_aw_q[$];

  logic [7:0]  img_mem [NPIX];
  logic [31:0] cur_m;
  bit          bp;
  int          ar_cnt, aw_cnt, b_cnt, cyc, last_b_cyc, ov_cyc;

  // read slave
  initial begin : rd_slave
    bit          rd_active, ar_hold;
    int          rd_beat, off;
    logic [31:0] rd_addr, ar_hold_addr;
    rd_active = 0; rd_beat = 0; rd_addr = 0; ar_hold = 0; ar_hold_addr = 0;
    arready = 0; rvalid = 0; rlast = 0; rdata = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        rd_active = 0; rd_beat = 0; ar_hold = 0;
      end else begin
        if (ar_hold) begin
          check_eq("arvalid_hold", arvalid, 1);
          check_eq("araddr_stable", araddr, ar_hold_addr);
        end
        ar_hold = arvalid && !arready;
        ar_hold_addr = araddr;
        if (rvalid && rready) begin
          rd_beat++;
          if (rd_beat == 16) rd_active = 0;
        end
        if (arvalid && arready) begin
          ar_cnt++;
          check_eq("arlen", arlen, 4'hF);
          if (exp_ar_q.size() == 0) check_eq("ar_queue_size", exp_ar_q.size(), 1);
          else check_eq("araddr", araddr, exp_ar_q.pop_front());
          rd_active = 1; rd_addr = araddr; rd_beat = 0;
        end
      end
      #1;
      if (rst) begin
        arready = 0; rvalid = 0; rlast = 0; rdata = 0;
      end else begin
        arready = !rd_active && (!bp || $urandom_range(0, 9) >= 3);
        if (rd_active) begin
          rvalid = !bp || $urandom_range(0, 9) >= 3;
          off = int'(rd_addr - cur_m) + 4 * rd_beat;
          for (int j = 0; j < 4; j++) rdata[8*j +: 8] = img_mem[(off + j) % NPIX];
          rlast = (rd_beat == 15);
        end else begin
          rvalid = 0; rlast = 0;
        end
      end
    end
  end

  // write slave
  initial begin : wr_slave
    bit          w_hold, b_pend;
    int          w_beat, aw_wait;
    logic [31:0] w_hold_data;
    w_hold = 0; b_pend = 0; w_beat = 0; aw_wait = 0; w_hold_data = 0; cyc = 0;
    awready = 0; wready = 0; bvalid = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        w_hold = 0; b_pend = 0; w_beat = 0; aw_wait = 0;
      end else begin
        if (w_hold) check_eq("wdata_stable", wdata, w_hold_data);
        w_hold = wvalid && !wready;
        w_hold_data = wdata;
        if (bvalid && bready) begin
          b_cnt++; last_b_cyc = cyc; b_pend = 0;
        end
        if (awvalid && awready) begin
          aw_cnt++; aw_wait = 0;
          check_eq("awlen", awlen, 4'hF);
          if (exp_aw_q.size() == 0) check_eq("aw_queue_size", exp_aw_q.size(), 1);
          else check_eq("awaddr", awaddr, exp_aw_q.pop_front());
        end else if (awvalid) begin
          aw_wait++;
        end
        if (wvalid && wready) begin
          for (int j = 0; j < 4; j++) begin
            if (exp_q.size() == 0) check_eq("w_queue_size", exp_q.size(), 1);
            else check_eq("cell", wdata[8*j +: 8], exp_q.pop_front());
          end
          check_eq("wlast", wlast, w_beat == 15);
          w_beat++;
          if (w_beat == 16) begin
            w_beat = 0; b_pend = 1;
          end
        end
        if (out_valid) ov_cyc = cyc;
      end
      #1;
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0;
      end else begin
        awready = bp ? (aw_wait >= 5) : 1'b1;
        wready  = !bp || $urandom_range(0, 9) >= 3;
        bvalid  = b_pend;
      end
    end
  end

  // driver tasks
  task automatic start_job(input logic [31:0] m, input logic [31:0] g, input logic [1:0] dir,
                           input logic [3:0] dis, input bit sym);
    int e [NCELL];
    int dr, dc, nr, nc, a, b;
    for (int i = 0; i < NCELL; i++) e[i] = 0;
    case (dir)
      2'b01:   begin dr = 0;        dc = int'(dis);  end
      2'b10:   begin dr = int'(dis); dc = 0;         end
      2'b11:   begin dr = int'(dis); dc = int'(dis); end
      default: begin dr = int'(dis); dc = -int'(dis); end
    endcase
    if (dis != 0) begin
      for (int r = 0; r < IMG_DIM; r++) begin
        for (int c = 0; c < IMG_DIM; c++) begin
          nr = r + dr; nc = c + dc;
          if (nr >= 0 && nr < IMG_DIM && nc >= 0 && nc < IMG_DIM) begin
            a = img_mem[r * IMG_DIM + c] % LEVELS;
            b = img_mem[nr * IMG_DIM + nc] % LEVELS;
            if (e[a * LEVELS + b] < 255) e[a * LEVELS + b]++;
            if (sym && e[b * LEVELS + a] < 255) e[b * LEVELS + a]++;
          end
        end
      end
    end
    for (int k = 0; k < 4; k++) exp_ar_q.push_back(m + 32'(64 * k));
    for (int k = 0; k < 16; k++) exp_aw_q.push_back(g + 32'(64 * k));
    for (int i = 0; i < NCELL; i++) exp_q.push_back(8'(e[i]));
    ar_cnt = 0; aw_cnt = 0; b_cnt = 0; ov_cyc = -1; last_b_cyc = -100;
    cur_m = m;
    @(posedge clk); #1;
    in_valid = 1; in_addr_M = m; in_addr_G = g; in_dir = dir; in_dis = dis; in_sym = sym;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic finish_job(input string tag);
    int t;
    t = 0;
    while (!out_valid && t < 20000) begin
      @(negedge clk); t++;
    end
    check_eq({tag, "_done_seen"}, out_valid, 1);
    check_eq({tag, "_busy_at_done"}, busy, 1);
    @(negedge clk);
    check_eq({tag, "_out_valid_one_cycle"}, out_valid, 0);
    check_eq({tag, "_busy_dropped"}, busy, 0);
    check_eq({tag, "_ar_bursts"}, ar_cnt, 4);
    check_eq({tag, "_aw_bursts"}, aw_cnt, 16);
    check_eq({tag, "_b_responses"}, b_cnt, 16);
    check_eq({tag, "_done_after_last_b"}, ov_cyc, last_b_cyc + 1);
    check_eq({tag, "_cells_left"}, exp_q.size(), 0);
    exp_q.delete(); exp_ar_q.delete(); exp_aw_q.delete();
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_arvalid"}, arvalid, 0);
    check_eq({tag, "_rready"}, rready, 0);
    check_eq({tag, "_awvalid"}, awvalid, 0);
    check_eq({tag, "_wvalid"}, wvalid, 0);
  endtask

  initial begin : watchdog
    #3000000;
    n_fail++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : main
    int t;
    rst = 1; in_valid = 0; in_addr_M = 0; in_addr_G = 0; in_dir = 0; in_dis = 0; in_sym = 0;
    bp = 0; cur_m = 0;
    ar_cnt = 0; aw_cnt = 0; b_cnt = 0; last_b_cyc = 0; ov_cyc = 0;
    for (int i = 0; i < NPIX; i++) img_mem[i] = 8'($urandom_range(0, 255));
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    check_idle("reset");
    check_eq("bready_tied", bready, 1);

    // abort mid read phase, then a clean job
    start_job(32'h0000_1000, 32'h0008_0000, 2'b01, 4'd1, 1'b0);
    t = 0;
    while (ar_cnt < 2 && t < 2000) begin
      @(posedge clk); t++;
    end
    check_eq("mid_rd_reached", ar_cnt >= 2, 1);
    #3 rst = 1;
    #1 check_idle("mid_reset");
    @(posedge clk); #2 rst = 0;
    exp_q.delete(); exp_ar_q.delete(); exp_aw_q.delete();
    @(negedge clk);
    check_idle("after_reset");

    // right, d=1, pixel = column
    for (int i = 0; i < NPIX; i++) img_mem[i] = 8'((i % IMG_DIM) % LEVELS);
    start_job(32'h0000_1000, 32'h0008_0000, 2'b01, 4'd1, 1'b0);
    finish_job("right_d1");

    // down-left, d=2, flat image, symmetric: saturates
    for (int i = 0; i < NPIX; i++) img_mem[i] = 8'd7;
    start_job(32'h0002_0040, 32'h0009_0000, 2'b00, 4'd2, 1'b1);
    finish_job("dl_sat");

    // down-right, d=15: a single corner pair; upper bits of bytes must be ignored
    for (int i = 0; i < NPIX; i++) img_mem[i] = 8'($urandom_range(0, 255));
    start_job(32'h0003_0000, 32'h000A_0400, 2'b11, 4'd15, 1'b0);
    finish_job("dr_d15");

    // down, d=0: invalid job still writes an all-zero matrix
    start_job(32'h0004_0000, 32'h000B_0000, 2'b10, 4'd0, 1'b1);
    finish_job("down_d0");

    // back-pressure plus a start request while busy
    bp = 1;
    for (int i = 0; i < NPIX; i++) img_mem[i] = 8'($urandom_range(0, 255));
    start_job(32'h0005_0000, 32'h000C_0000, 2'b01, 4'd3, 1'b1);
    repeat (20) @(posedge clk);
    #1 in_valid = 1; in_addr_M = 32'h0007_0000; in_addr_G = 32'h000D_0000;
    in_dir = 2'b10; in_dis = 4'd5; in_sym = 0;
    @(posedge clk); #1 in_valid = 0;
    finish_job("bp_right_d3");

    for (int i = 0; i < NPIX; i++) img_mem[i] = 8'($urandom_range(0, 255));
    start_job(32'h0006_0000, 32'h000E_0000, 2'b10, 4'd4, 1'b0);
    finish_job("bp_down_d4");
    bp = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/glcm_engine_p.md
Name: glcm_engine_p

Overview:
- Parametrised successor of the fixed 16x16/32-level GLCM block.
- Fetches an IMG_DIM x IMG_DIM image from DRAM over AXI4 INCR-16 read bursts and accumulates a LEVELS x LEVELS co-occurrence matrix for one (dir, dis) offset, with optional symmetric counting and saturating counts.
- Writes the matrix back over AXI4 burst writes, then pulses out_valid.
- Sits between the pattern-input testbench interface and pseudo-DRAM.

Parameters:
IMG_DIM, 16, image side in pixels; power of 2, 8..32
GRAY_BITS, 5, pixel bits; LEVELS = 2^GRAY_BITS; 3..6
CNT_W, 8, count width; counts saturate at 2^CNT_W-1; 8 only (one count per byte lane)
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width; 4 byte lanes per beat

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, reset is asynchronous and active-high
in_valid  in  1  one-cycle job start; accepted only when busy=0
in_addr_M  in  ADDR_W  image base address, 64-byte aligned
in_addr_G  in  ADDR_W  matrix base address, 64-byte aligned
in_dir  in  2  01 right (0,+d), 10 down (+d,0), 11 down-right (+d,+d), 00 down-left (+d,-d)
in_dis  in  4  distance d
in_sym  in  1  1 = symmetric counting
busy  out  1  high from the accepted in_valid through the out_valid cycle
out_valid  out  1  one-cycle done pulse
araddr / arlen / arvalid / arready  out/out/out/in  ADDR_W/4/1/1  read address; arlen fixed 4'hF
rdata / rlast / rvalid / rready  in/in/in/out  DATA_W/1/1/1  read data
awaddr / awlen / awvalid / awready  out/out/out/in  ADDR_W/4/1/1  write address; awlen fixed 4'hF
wdata / wlast / wvalid / wready  out/out/out/in  DATA_W/1/1/1  write data
bvalid / bready  in/out  1/1  write response; bready tied 1

Behaviour:
- Reset: all outputs 0, FSM=IDLE, image buffer cleared, count memory cleared.
- FSM states: IDLE -> RD_AR -> RD_R -> (RD_AR while image bursts remain) -> ACCUM -> WR_AW -> WR_W -> WR_B -> (WR_AW while matrix bursts remain) -> DONE -> IDLE.
- Job acceptance: in_valid latches all inputs and clears the count memory.
- Invalid job: in_dis=0 or in_dis>=IMG_DIM. No pair is counted; the full all-zero matrix is still written back.
- Read phase:
  - NR = IMG_DIM^2/64 bursts. Burst k address = in_addr_M + 64k.
  - arvalid holds until arready; araddr stays stable while arvalid=1.
  - rready=1 only in RD_R.
  - Beat byte lane j holds pixel 4*beat+j in raster order. Only bits [GRAY_BITS-1:0] of each lane are stored.
  - rlast on the final beat of burst NR-1 moves the FSM to ACCUM.
- ACCUM phase:
  - Reference pixel (r,c) is scanned in raster order; neighbour is (r+dr, c+dc).
  - Pairs with an out-of-range neighbour, including negative c for dir 00, are skipped with zero cycles spent.
  - One count update per cycle: cnt[a][b] += 1 (a = reference, b = neighbour).
  - If in_sym=1, each pair takes two cycles: cnt[a][b] then cnt[b][a]. For a==b this gives +2.
  - Updates saturate at 255 and never wrap.
  - Read-modify-write pipeline forwards back-to-back updates to the same cell; no count is lost.
- Write phase:
  - NW = LEVELS^2/64 bursts. Burst k address = in_addr_G + 64k.
  - Beat n carries cells 4n..4n+3 in row-major order (index = a*LEVELS+b), lowest index in byte [7:0].
  - wvalid asserts only after the AW handshake of the same burst. wdata holds stable while wvalid=1 and wready=0.
  - wlast on beat 15. The next AW issues only after bvalid.
- DONE: out_valid=1 for exactly one cycle, busy drops the next cycle, and the count memory keeps its contents until the next job.
- Error cases:
  - in_valid while busy=1 is ignored.
  - rst mid-job aborts immediately to reset state, with no further AXI valids.

Test Plan:
- Reset: assert rst mid RD_R -> all valids 0 next edge, busy=0; a following job completes correctly.
- Default params, dir=01 d=1, image pixel(r,c)=c%32 -> cnt[c][c+1]=16 for c=0..14; row 15 of matrix all 0; 16 write bursts, out_valid one cycle after last bvalid.
- dir=00 d=2, image all 7, in_sym=1 -> cnt[7][7]=min(2*14*14,255)=255 (saturation), all other cells 0.
- dir=11 d=15, in_sym=0 -> exactly one pair counted (pixel(0,0), pixel(15,15)).
- dir=10 d=0 -> all-zero matrix written, out_valid still pulses.
- Back-pressure: arready/wready random 30% and awready delayed 5 cycles -> identical DRAM contents. in_valid during busy is ignored.
